// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, bit-period timer and frame FSM.
// Recovers DATA_BITS LSB-first data with optional odd parity and break lockout.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Sin,
    output logic [DATA_BITS-1:0] Dout,
    output logic                 Receive,
    output logic                 parityErr,
    output logic                 frameErr,
    output logic                 busy
);

    localparam int unsigned TIMER_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TIMER_W-1:0] HALF_CNT = TIMER_W'(HALF_BIT - 1);
    localparam logic [TIMER_W-1:0] FULL_CNT = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic               PAR_ON   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } stateT;

    stateT                state;
    stateT                stateNext;
    logic                 syncMeta;
    logic                 s;
    logic [TIMER_W-1:0]   timer;
    logic [IDX_W-1:0]     bitIdx;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 parityBit;
    logic                 armed;
    logic                 halfHit;
    logic                 fullHit;
    logic                 timerClear;

    // Two-flop synchronizer; idles high so reset does not look like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncMeta <= 1'b1;
            s        <= 1'b1;
        end else begin
            syncMeta <= Sin;
            s        <= syncMeta;
        end
    end

    assign halfHit = (timer == HALF_CNT);
    assign fullHit = (timer == FULL_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        timerClear = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !s) begin
                    stateNext = START;
                end
            end
            START: begin
                if (halfHit) begin
                    stateNext = s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (fullHit && (bitIdx == LAST_IDX)) begin
                    stateNext = PAR_ON ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (fullHit) begin
                    stateNext = STOP;
                end
            end
            STOP: begin
                if (fullHit) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        timerClear = (state == IDLE) || fullHit || (stateNext != state);
    end

    // Timer, sampling datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer     <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
            armed     <= 1'b1;
            Dout      <= '0;
            Receive   <= 1'b0;
            parityErr <= 1'b0;
            frameErr  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            Receive <= 1'b0;
            busy    <= (stateNext != IDLE);
            timer   <= timerClear ? '0 : timer + TIMER_W'(1);
            case (state)
                IDLE: begin
                    if (s) begin
                        armed <= 1'b1;
                    end
                end
                START: begin
                    bitIdx <= '0;
                end
                DATA: begin
                    if (fullHit) begin
                        shiftReg[bitIdx] <= s;
                        bitIdx           <= bitIdx + IDX_W'(1);
                    end
                end
                PARITY: begin
                    if (fullHit) begin
                        parityBit <= s;
                    end
                end
                STOP: begin
                    if (fullHit) begin
                        Dout      <= shiftReg;
                        parityErr <= PAR_ON & ~(^shiftReg ^ parityBit);
                        frameErr  <= ~s;
                        Receive   <= 1'b1;
                        // A low stop bit locks out new frames until the line goes high.
                        if (!s) begin
                            armed <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: parity instance on line A, no-parity instance on line B.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       sinA;
    logic       sinB;
    logic [7:0] doutA;
    logic [7:0] doutB;
    logic       recvA;
    logic       recvB;
    logic       pErrA;
    logic       pErrB;
    logic       fErrA;
    logic       fErrB;
    logic       busyA;
    logic       busyB;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int recvCntA = 0;
    int recvCntB = 0;
    int doublePulse = 0;
    logic prevRecvA = 1'b0;
    logic prevRecvB = 1'b0;
    logic busyAtRecvA = 1'b1;
    int recvCycB [4];
    logic [7:0] doutAtB [4];

    uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(CPB / 2), .DATA_BITS(8), .PARITY_EN(1)) dutA (
        .clk(clk), .rst(rst), .Sin(sinA), .Dout(doutA), .Receive(recvA),
        .parityErr(pErrA), .frameErr(fErrA), .busy(busyA)
    );

    uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(CPB / 2), .DATA_BITS(8), .PARITY_EN(0)) dutB (
        .clk(clk), .rst(rst), .Sin(sinB), .Dout(doutB), .Receive(recvB),
        .parityErr(pErrB), .frameErr(fErrB), .busy(busyB)
    );

    always #5 clk = ~clk;

    // Pulse monitor sampled on the inactive edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (recvA) begin
            recvCntA = recvCntA + 1;
            busyAtRecvA = busyA;
        end
        if (recvB) begin
            if (recvCntB < 4) begin
                recvCycB[recvCntB] = cyc;
                doutAtB[recvCntB] = doutB;
            end
            recvCntB = recvCntB + 1;
        end
        if ((recvA && prevRecvA) || (recvB && prevRecvB)) begin
            doublePulse = doublePulse + 1;
        end
        prevRecvA = recvA;
        prevRecvB = recvB;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sendBit(input bit sel, input logic v);
        @(posedge clk);
        #1;
        if (sel) sinB = v;
        else sinA = v;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic sendFrame(input bit sel, input logic [7:0] d, input bit withPar,
                             input logic p, input logic stopBit);
        sendBit(sel, 1'b0);
        for (int i = 0; i < 8; i++) sendBit(sel, d[i]);
        if (withPar) sendBit(sel, p);
        sendBit(sel, stopBit);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        sinA = 1'b1;
        sinB = 1'b1;
        idle(3);
        #1;
        checkVal("rst_dout", 32'(doutA), 32'h0);
        checkVal("rst_receive", 32'(recvA), 32'h0);
        checkVal("rst_parityErr", 32'(pErrA), 32'h0);
        checkVal("rst_frameErr", 32'(fErrA), 32'h0);
        checkVal("rst_busy", 32'(busyA), 32'h0);
        rst = 1'b0;
        idle(4);

        // Normal byte with correct odd parity.
        sendFrame(0, 8'h55, 1, 1'b1, 1'b1);
        idle(8);
        #1;
        checkVal("n55_count", 32'(recvCntA), 32'd1);
        checkVal("n55_dout", 32'(doutA), 32'h55);
        checkVal("n55_parityErr", 32'(pErrA), 32'h0);
        checkVal("n55_frameErr", 32'(fErrA), 32'h0);
        checkVal("n55_busyAtRecv", 32'(busyAtRecvA), 32'h0);

        // Wrong parity, then a byte whose correct parity is 0.
        sendFrame(0, 8'h55, 1, 1'b0, 1'b1);
        idle(8);
        #1;
        checkVal("pe_count", 32'(recvCntA), 32'd2);
        checkVal("pe_dout", 32'(doutA), 32'h55);
        checkVal("pe_parityErr", 32'(pErrA), 32'h1);
        checkVal("pe_frameErr", 32'(fErrA), 32'h0);
        sendFrame(0, 8'h07, 1, 1'b0, 1'b1);
        idle(8);
        #1;
        checkVal("p07_dout", 32'(doutA), 32'h07);
        checkVal("p07_parityErr", 32'(pErrA), 32'h0);

        // Glitch shorter than half a bit.
        @(posedge clk);
        #1 sinA = 1'b0;
        repeat (CPB / 4) @(posedge clk);
        #1 sinA = 1'b1;
        checkVal("gl_busyHigh", 32'(busyA), 32'h1);
        idle(2 * CPB);
        #1;
        checkVal("gl_busyLow", 32'(busyA), 32'h0);
        checkVal("gl_count", 32'(recvCntA), 32'd3);
        checkVal("gl_dout", 32'(doutA), 32'h07);

        // Break: 0x00 frame then line held low for 5 frame times.
        sendFrame(0, 8'h00, 1, 1'b1, 1'b0);
        idle(5 * 11 * CPB);
        #1;
        checkVal("brk_count", 32'(recvCntA), 32'd4);
        checkVal("brk_dout", 32'(doutA), 32'h00);
        checkVal("brk_frameErr", 32'(fErrA), 32'h1);
        checkVal("brk_parityErr", 32'(pErrA), 32'h0);
        sendBit(0, 1'b1);
        sendFrame(0, 8'hA3, 1, 1'b1, 1'b1);
        idle(8);
        #1;
        checkVal("brkA3_count", 32'(recvCntA), 32'd5);
        checkVal("brkA3_dout", 32'(doutA), 32'hA3);
        checkVal("brkA3_frameErr", 32'(fErrA), 32'h0);

        // Reset asserted during data bit 3 of 0xFF.
        sendBit(0, 1'b0);
        for (int i = 0; i < 3; i++) sendBit(0, 1'b1);
        @(posedge clk);
        #1 sinA = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkVal("mrst_dout", 32'(doutA), 32'h0);
        checkVal("mrst_busy", 32'(busyA), 32'h0);
        checkVal("mrst_receive", 32'(recvA), 32'h0);
        checkVal("mrst_frameErr", 32'(fErrA), 32'h0);
        idle(2);
        #1 rst = 1'b0;
        idle(3 * CPB);
        #1;
        checkVal("mrst_count", 32'(recvCntA), 32'd5);
        sendFrame(0, 8'h3C, 1, 1'b1, 1'b1);
        idle(8);
        #1;
        checkVal("r3C_count", 32'(recvCntA), 32'd6);
        checkVal("r3C_dout", 32'(doutA), 32'h3C);
        checkVal("r3C_parityErr", 32'(pErrA), 32'h0);

        // Back-to-back frames without parity on line B.
        sendFrame(1, 8'hA3, 0, 1'b0, 1'b1);
        sendFrame(1, 8'h00, 0, 1'b0, 1'b1);
        idle(20);
        #1;
        checkVal("b2b_count", 32'(recvCntB), 32'd2);
        checkVal("b2b_spacing", 32'(recvCycB[1] - recvCycB[0]), 32'(10 * CPB));
        checkVal("b2b_dout0", 32'(doutAtB[0]), 32'hA3);
        checkVal("b2b_dout1", 32'(doutAtB[1]), 32'h00);
        checkVal("b2b_parityErr", 32'(pErrB), 32'h0);
        checkVal("b2b_frameErr", 32'(fErrB), 32'h0);
        checkVal("pulse_width", 32'(doublePulse), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
